// File: rtl/mult_arbiter.sv
// mult_arbiter: shares one external sequential multiplier among NREQ
// requesters with round-robin arbitration. One operation is in flight at
// a time: IDLE (arbitrate) -> ISSUE (start pulse) -> WAIT (until done)
// -> RESP (one-cycle response pulse to the winner).
//
// Optional build macro: MULT_ARB_TIMEOUT_EN adds a watchdog that ends a
// WAIT lasting TIMEOUT cycles with resp_err_o=1 and a zero product.
//
// Handshake summary: req_valid_i is a level held by the requester until
// its req_ready_o bit pulses for one cycle (acceptance); the result is
// returned as a one-cycle resp_valid_o pulse on the same requester's bit,
// with resp_product_o/resp_err_o qualified by that pulse. Towards the
// multiplier, mult_valid_o is a one-cycle start pulse, operands stay
// stable until completion, and mult_done_i is a level.
module mult_arbiter #(
  parameter int WIDTH   = 32,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [NREQ-1:0]            req_valid_i,
  input  logic [NREQ*WIDTH-1:0]      req_opa_i,
  input  logic [NREQ*WIDTH-1:0]      req_opb_i,
  output logic [NREQ-1:0]            req_ready_o,
  output logic [NREQ-1:0]            resp_valid_o,
  output logic [WIDTH-1:0]           resp_product_o,
  output logic                       resp_err_o,
  output logic                       mult_valid_o,
  output logic [WIDTH-1:0]           mult_opa_o,
  output logic [WIDTH-1:0]           mult_opb_o,
  input  logic                       mult_done_i,
  input  logic [WIDTH-1:0]           mult_product_i,
  output logic [1:0]                 state_o,
  output logic [$clog2(NREQ)-1:0]    rr_ptr_o
);

  localparam int PW = $clog2(NREQ);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  // Reject unsupported configurations at elaboration time.
  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_bad_params
    $error("mult_arbiter: NREQ must be 2..8 and TIMEOUT at least 1");
  end

  state_e            state_q, state_d;
  logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]     win_q, win_d;
  logic              first_wait_q, first_wait_d;
  logic [NREQ-1:0]   req_ready_q, req_ready_d;
  logic [NREQ-1:0]   resp_valid_q, resp_valid_d;
  logic [WIDTH-1:0]  resp_product_q, resp_product_d;
  logic              mult_valid_q, mult_valid_d;
  logic [WIDTH-1:0]  mult_opa_q, mult_opa_d;
  logic [WIDTH-1:0]  mult_opb_q, mult_opb_d;

`ifdef MULT_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              resp_err_q, resp_err_d;
`endif

  logic [WIDTH-1:0]  opa_arr [NREQ];
  logic [WIDTH-1:0]  opb_arr [NREQ];
  logic [PW-1:0]     pick;
  logic              found;
  logic [NREQ-1:0]   pick_oh;
  logic [NREQ-1:0]   win_oh;
  logic [PW-1:0]     win_next;

  // Split the flat operand buses into per-requester slices.
  always_comb begin
    for (int k = 0; k < NREQ; k++) begin
      opa_arr[k] = req_opa_i[k*WIDTH +: WIDTH];
      opb_arr[k] = req_opb_i[k*WIDTH +: WIDTH];
    end
  end

  // Round-robin scan: first requesting index at or after rr_ptr, wrapping.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      logic [PW-1:0] idx;
      idx = PW'((int'(rr_ptr_q) + k) % NREQ);
      if (!found && req_valid_i[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign pick_oh  = NREQ'(1) << pick;
  assign win_oh   = NREQ'(1) << win_q;
  assign win_next = (win_q == PW'(NREQ - 1)) ? '0 : win_q + PW'(1);

  // Next-state and registered-output computation for the arbiter FSM.
  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    win_d          = win_q;
    first_wait_d   = first_wait_q;
    req_ready_d    = '0;
    resp_valid_d   = '0;
    resp_product_d = resp_product_q;
    mult_valid_d   = 1'b0;
    mult_opa_d     = mult_opa_q;
    mult_opb_d     = mult_opb_q;
`ifdef MULT_ARB_TIMEOUT_EN
    cnt_d          = cnt_q;
    resp_err_d     = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        if (found) begin
          win_d        = pick;
          mult_opa_d   = opa_arr[pick];
          mult_opb_d   = opb_arr[pick];
          mult_valid_d = 1'b1;
          req_ready_d  = pick_oh;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        // A done still high from the previous operation must not count.
        first_wait_d = 1'b1;
`ifdef MULT_ARB_TIMEOUT_EN
        cnt_d        = '0;
`endif
        state_d      = WAIT;
      end
      WAIT: begin
        first_wait_d = 1'b0;
        if (!first_wait_q && mult_done_i) begin
          resp_product_d = mult_product_i;
          resp_valid_d   = win_oh;
          state_d        = RESP;
        end
`ifdef MULT_ARB_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT - 1)) begin
          resp_product_d = '0;
          resp_valid_d   = win_oh;
          resp_err_d     = 1'b1;
          state_d        = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
`endif
      end
      RESP: begin
        rr_ptr_d = win_next;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any operation in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= IDLE;
      rr_ptr_q       <= '0;
      win_q          <= '0;
      first_wait_q   <= 1'b0;
      req_ready_q    <= '0;
      resp_valid_q   <= '0;
      resp_product_q <= '0;
      mult_valid_q   <= 1'b0;
      mult_opa_q     <= '0;
      mult_opb_q     <= '0;
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      win_q          <= win_d;
      first_wait_q   <= first_wait_d;
      req_ready_q    <= req_ready_d;
      resp_valid_q   <= resp_valid_d;
      resp_product_q <= resp_product_d;
      mult_valid_q   <= mult_valid_d;
      mult_opa_q     <= mult_opa_d;
      mult_opb_q     <= mult_opb_d;
    end
  end

`ifdef MULT_ARB_TIMEOUT_EN
  // Watchdog counter and error flag registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q      <= '0;
      resp_err_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      resp_err_q <= resp_err_d;
    end
  end
  assign resp_err_o = resp_err_q;
`else
  assign resp_err_o = 1'b0;
`endif

  assign req_ready_o    = req_ready_q;
  assign resp_valid_o   = resp_valid_q;
  assign resp_product_o = resp_product_q;
  assign mult_valid_o   = mult_valid_q;
  assign mult_opa_o     = mult_opa_q;
  assign mult_opb_o     = mult_opb_q;
  assign state_o        = state_q;
  assign rr_ptr_o       = rr_ptr_q;

endmodule
